// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select, load-use stall and branch-flush control for a 5-stage pipeline.
// Tracks EX/MEM/WB register-usage records and counts load-use stall cycles (saturating).
module fwd_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_is_load,
    input  logic             branch_taken,
    output logic [1:0]       mux1_sel,
    output logic [1:0]       mux2_sel,
    output logic             stall,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       regwrite;
        logic       is_load;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    stage_t           ex_q, ex_d;
    stage_t           mem_q;
    stage_t           wb_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             load_use;
    logic [1:0][4:0]  src_w;
    logic [3:0]       sel_w;
    logic             unused_wb_bits;

    function automatic logic writer_match(input stage_t s, input logic [4:0] r);
        return s.valid & s.regwrite & (s.rd != 5'd0) & (s.rd == r);
    endfunction

    assign src_w = {ex_q.rs2, ex_q.rs1};

    // Nearer producer (MEM) takes precedence over the older one (WB).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign sel_w[2*gi +: 2] = !ex_q.valid                     ? 2'b00 :
                                      writer_match(mem_q, src_w[gi]) ? 2'b01 :
                                      writer_match(wb_q,  src_w[gi]) ? 2'b10 :
                                                                       2'b00;
        end
    endgenerate

    assign mux1_sel = sel_w[1:0];
    assign mux2_sel = sel_w[3:2];

    assign flush    = branch_taken & ex_q.valid;
    assign load_use = id_valid & ex_q.valid & ex_q.is_load & (ex_q.rd != 5'd0) &
                      ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
    assign stall    = load_use & ~flush;

    always_comb begin
        ex_d        = BUBBLE;
        stall_cnt_d = stall_cnt_q;
        if (!(stall | flush)) begin
            ex_d.valid    = id_valid;
            ex_d.rs1      = id_rs1;
            ex_d.rs2      = id_rs2;
            ex_d.rd       = id_rd;
            ex_d.regwrite = id_regwrite & id_valid;
            ex_d.is_load  = id_is_load & id_valid;
        end
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q        <= BUBBLE;
            mem_q       <= BUBBLE;
            wb_q        <= BUBBLE;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

    // WB sources and load flag are kept for record completeness only.
    assign unused_wb_bits = ^{wb_q.rs1, wb_q.rs2, wb_q.is_load};

endmodule
